// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared opcodes, error codes and scheduler state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int W_DEF = 6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_DIV = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_watchdog.sv
// ============================================================================
// div_watchdog : clear/enable cycle counter, flags the LIMIT-th enabled cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module div_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  // High during the LIMIT-th enabled cycle so the owner can act on that edge.
  assign expired_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer : schedules add/sub/mul locally and div on the shared divider
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DIV_TIMEOUT = 15,
  parameter int W           = W_DEF
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [1:0]     op_code,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           div_start,
  output logic [W-1:0]   div_m,
  output logic [W-1:0]   div_q,
  input  logic           div_done,
  input  logic [2*W-1:0] div_result,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic [1:0]     res_err,
  output logic           busy
);

  state_e         state_q;
  logic           op_ready_q, div_start_q, res_valid_q, busy_q;
  logic [W-1:0]   div_m_q, div_q_q;
  logic [2*W-1:0] res_data_q;
  logic [1:0]     res_err_q;
  logic [2*W-1:0] a_ext, b_ext, arith_d;
  logic           accept, wd_expired;

  assign accept = (state_q == ST_IDLE) && op_valid && op_ready_q;

  // Zero-extended operands make sub wrap into a sign-extended 2W result.
  always_comb begin
    a_ext   = {{W{1'b0}}, op_a};
    b_ext   = {{W{1'b0}}, op_b};
    arith_d = '0;
    case (op_code)
      OP_ADD:  arith_d = a_ext + b_ext;
      OP_SUB:  arith_d = a_ext - b_ext;
      OP_MUL:  arith_d = a_ext * b_ext;
      default: arith_d = '0;
    endcase
  end

  div_watchdog #(
    .LIMIT(DIV_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr_i    (state_q == ST_ISSUE),
    .en_i     (state_q == ST_WAIT_DIV),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      op_ready_q  <= 1'b0;
      div_start_q <= 1'b0;
      div_m_q     <= '0;
      div_q_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= ERR_OK;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (op_code != OP_DIV) begin
              res_data_q  <= arith_d;
              res_err_q   <= ERR_OK;
              res_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end else if (op_b == '0) begin
              res_data_q  <= '0;
              res_err_q   <= ERR_DIV0;
              res_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end else begin
              div_m_q     <= op_b;
              div_q_q     <= op_a;
              div_start_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end
          end else begin
            op_ready_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          div_start_q <= 1'b0;
          state_q     <= ST_WAIT_DIV;
        end
        ST_WAIT_DIV: begin
          // A done pulse on the timeout cycle still delivers the real result.
          if (div_done) begin
            res_data_q  <= div_result;
            res_err_q   <= ERR_OK;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else if (wd_expired) begin
            res_data_q  <= '0;
            res_err_q   <= ERR_TMO;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready  = op_ready_q;
  assign div_start = div_start_q;
  assign div_m     = div_m_q;
  assign div_q     = div_q_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer : vector table, corner sequences and random ops vs a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam int W   = 6;
  localparam int TMO = 15;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [1:0]      op_code = 2'b00;
  logic [W-1:0]    op_a = '0;
  logic [W-1:0]    op_b = '0;
  logic            div_start;
  logic [W-1:0]    div_m, div_q;
  logic            div_done;
  logic [2*W-1:0]  div_result;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [2*W-1:0]  res_data;
  logic [1:0]      res_err;
  logic            busy;

  always #5 clk = ~clk;

  alu_sequencer #(.DIV_TIMEOUT(TMO), .W(W)) dut (
    .clk(clk), .n_rst(n_rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b),
    .div_start(div_start), .div_m(div_m), .div_q(div_q),
    .div_done(div_done), .div_result(div_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  // Divider stand-in: done pulses dv_lat cycles after the start cycle.
  int           dv_lat = 7;
  bit           dv_en = 1'b1;
  bit           stray_req = 1'b0;
  int           dv_rem = 0;
  logic [W-1:0] dv_a, dv_b;

  always @(negedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dv_rem     = 0;
      div_done   = 1'b0;
      div_result = '0;
    end else begin
      div_done   = 1'b0;
      div_result = '0;
      if (dv_rem > 0) begin
        dv_rem--;
        if (dv_rem == 0) begin
          div_done   = 1'b1;
          div_result = {dv_a % dv_b, dv_a / dv_b};
        end
      end
      if (stray_req) begin
        div_done   = 1'b1;
        div_result = 12'hABC;
        stray_req  = 1'b0;
      end
      if (div_start && dv_en) begin
        dv_rem = dv_lat;
        dv_a   = div_q;
        dv_b   = div_m;
      end
    end
  end

  int cyc = 0, start_cnt = 0, start_cyc = -1;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (div_start) begin start_cnt++; start_cyc = cyc; end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; issues one op, waits for its result, consumes it.
  task automatic run_op(input string nm, input logic [1:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [11:0] ed,
                        input logic [1:0] ee, input int elat);
    int n, lat, acc, s0;
    s0 = start_cnt;
    op_code = c; op_a = a; op_b = b; op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 40) begin @(negedge clk); n++; end
    chk({nm, " accept"}, 32'(n < 40), 32'd1);
    acc = cyc;
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 60) begin @(negedge clk); lat++; end
    chk({nm, " latency"}, lat, elat);
    chk({nm, " data"}, 32'(res_data), 32'(ed));
    chk({nm, " err"}, 32'(res_err), 32'(ee));
    chk({nm, " starts"}, start_cnt - s0, 32'(c == 2'b11 && b != 0));
    if (c == 2'b11 && b != 0) chk({nm, " start cycle"}, start_cyc, acc + 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, " release"}, 32'(res_valid), 32'd0);
  endtask

  // Reference behaviour written straight from the arithmetic rules.
  task automatic model(input logic [1:0] c, input int a, input int b, input int lat,
                       output logic [11:0] ed, output logic [1:0] ee, output int elat);
    ee = 2'b00; elat = 1;
    case (c)
      2'b00: ed = 12'(a + b);
      2'b01: ed = 12'((a - b) & 'hFFF);
      2'b10: ed = 12'(a * b);
      default: begin
        if (b == 0) begin
          ed = 0; ee = 2'b01;
        end else if (lat <= TMO) begin
          ed = 12'((a % b) * 64 + a / b); elat = 2 + lat;
        end else begin
          ed = 0; ee = 2'b10; elat = 2 + TMO;
        end
      end
    endcase
  endtask

  typedef struct {
    logic [1:0]  c;
    logic [5:0]  a, b;
    int          lat;
    logic [11:0] ed;
    logic [1:0]  ee;
    int          elat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] ed;
    logic [1:0]  ee;
    int          elat, l;
    logic [1:0]  c;
    logic [5:0]  a, b;
    bit          stab;

    vecs[0]  = '{2'b11, 6'd45, 6'd6,  7,  12'h0C7, 2'b00, 9};
    vecs[1]  = '{2'b11, 6'd17, 6'd0,  7,  12'h000, 2'b01, 1};
    vecs[2]  = '{2'b10, 6'd63, 6'd63, 7,  12'hF81, 2'b00, 1};
    vecs[3]  = '{2'b01, 6'd5,  6'd9,  7,  12'hFFC, 2'b00, 1};
    vecs[4]  = '{2'b00, 6'd63, 6'd63, 7,  12'h07E, 2'b00, 1};
    vecs[5]  = '{2'b01, 6'd0,  6'd63, 7,  12'hFC1, 2'b00, 1};
    vecs[6]  = '{2'b11, 6'd5,  6'd9,  3,  12'h140, 2'b00, 5};
    vecs[7]  = '{2'b11, 6'd63, 6'd63, 15, 12'h001, 2'b00, 17};
    vecs[8]  = '{2'b11, 6'd50, 6'd7,  16, 12'h000, 2'b10, 17};
    vecs[9]  = '{2'b00, 6'd3,  6'd4,  7,  12'h007, 2'b00, 1};
    vecs[10] = '{2'b10, 6'd0,  6'd55, 7,  12'h000, 2'b00, 1};
    vecs[11] = '{2'b11, 6'd63, 6'd1,  1,  12'h03F, 2'b00, 3};

    // Reset state and first-cycle op_ready
    repeat (2) @(negedge clk);
    chk("reset outputs", 32'({op_ready, div_start, div_m, div_q, res_valid, res_data, res_err, busy}), 0);
    n_rst = 1'b1;
    #1 chk("op_ready first cycle", 32'(op_ready), 0);
    @(negedge clk);
    chk("op_ready idle", 32'(op_ready), 1);
    chk("busy idle", 32'(busy), 0);

    foreach (vecs[i]) begin
      dv_lat = vecs[i].lat;
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b,
             vecs[i].ed, vecs[i].ee, vecs[i].elat);
    end
    dv_lat = 7;

    // Divider never answers, then a plain add
    dv_en = 1'b0;
    run_op("no-done timeout", 2'b11, 6'd20, 6'd3, 12'h000, 2'b10, 2 + TMO);
    dv_en = 1'b1;
    run_op("add after timeout", 2'b00, 6'd3, 6'd4, 12'h007, 2'b00, 1);

    // Stray done in IDLE must be ignored
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray idle valid", 32'({res_valid, busy}), 0);
    run_op("add after stray", 2'b00, 6'd10, 6'd11, 12'h015, 2'b00, 1);

    // Backpressure: result held 20 cycles with a second op pending
    op_code = 2'b00; op_a = 6'd1; op_b = 6'd2; op_valid = 1'b1;
    @(negedge clk);
    op_a = 6'd10; op_b = 6'd20;
    stab = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (res_valid !== 1'b1 || res_data !== 12'h003 || op_ready !== 1'b0) stab = 1'b0;
      @(negedge clk);
    end
    chk("hold stable", 32'(stab), 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("after handshake", 32'({res_valid, op_ready}), 32'b01);
    @(negedge clk);
    op_valid = 1'b0;
    chk("second op result", 32'({res_valid, res_data}), 32'({1'b1, 12'h01E}));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("single result", 32'(res_valid), 0);

    // Asynchronous reset during WAIT_DIV
    dv_en = 1'b0;
    op_code = 2'b11; op_a = 6'd20; op_b = 6'd3; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy before reset", 32'(busy), 1);
    #2 n_rst = 1'b0;
    #1 chk("async reset outputs", 32'({op_ready, div_start, div_m, div_q, res_valid, res_data, res_err, busy}), 0);
    @(negedge clk);
    n_rst = 1'b1; dv_en = 1'b1; dv_lat = 7;
    #1 chk("op_ready after reset", 32'(op_ready), 0);
    @(negedge clk);
    run_op("div 63/1 after reset", 2'b11, 6'd63, 6'd1, 12'h03F, 2'b00, 9);

    // Random ops against the reference model
    for (int r = 0; r < 60; r++) begin
      c = 2'($urandom_range(0, 3));
      a = 6'($urandom_range(0, 63));
      b = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      l = $urandom_range(1, 17);
      dv_lat = l;
      model(c, int'(a), int'(b), l, ed, ee, elat);
      run_op($sformatf("rand%0d", r), c, a, b, ed, ee, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
